id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus operand forwarding for the 5-stage MIPS pipe. Captures decoded
//  fields from ID, resolves RAW hazards from EX/MEM and MEM/WB, and drives the ALU's A, B and
//  ALUOp directly. Also flags load-use hazards to the hazard unit. Sits directly upstream of alu.
// PARAMETERS
//  DW   32  datapath width
//  RW   5   register-address width
//  OPW  4   ALUOp width (NOP = 4'b0000)
// PORTS
//  clk           in   1    clock, rising edge
//  rstn          in   1    asynchronous reset, active low
//  hold_i        in   1    freeze stage (downstream stall)
//  bubble_i      in   1    load NOP instead of ID contents (load-use / branch flush)
//  id_valid      in   1    ID holds a real instruction
//  id_rs,id_rt   in   RW   source register numbers
//  id_rd         in   RW   destination register number (already muxed rt/rd)
//  id_rs_data    in   DW   regfile read data for rs
//  id_rt_data    in   DW   regfile read data for rt
//  id_imm        in   DW   extended immediate
//  id_shamt      in   5    shift amount field
//  id_aluop      in   OPW  ALU operation
//  id_bsel_imm   in   1    ALU B = immediate
//  id_asel_shamt in   1    ALU A = zero-extended shamt
//  id_regwrite,id_memread,id_memwrite,id_memtoreg  in 1 each  control bits
//  exm_regwrite  in   1    EX/MEM writes a register
//  exm_rd        in   RW   EX/MEM destination
//  exm_result    in   DW   EX/MEM ALU result
//  mwb_regwrite  in   1    MEM/WB writes a register
//  mwb_rd        in   RW   MEM/WB destination
//  mwb_result    in   DW   MEM/WB writeback value
//  ex_valid      out  1    EX holds a real instruction
//  alu_a,alu_b   out  DW   ALU operands
//  alu_op        out  OPW  ALU operation
//  ex_store_data out  DW   forwarded rt value for SW
//  ex_rd         out  RW   destination passed to EX/MEM
//  ex_regwrite,ex_memread,ex_memwrite,ex_memtoreg  out 1 each
//  load_use_o    out  1    load-use hazard detected (combinational)
// BEHAVIOUR
//  - Reset (rstn=0, async): all state 0; ex_valid=0, alu_op=NOP, all control outs 0, data 0.
//  - Edge update priority: hold_i > bubble_i > load. hold: keep fields, but refresh rs/rt data
//    with currently forwarded values (source may retire during hold). bubble: valid, control
//    bits, rd, aluop cleared; data don't-care. load: capture all id_* fields.
//  - Capture bypass: when loading, if mwb_regwrite & mwb_rd!=0 & mwb_rd==id_rs, store
//    mwb_result instead of id_rs_data; same for rt. Regfile same-cycle write needs no other care.
//  - Forwarding (comb, on latched rs/rt): EX/MEM first if exm_regwrite & exm_rd!=0 & match;
//    else MEM/WB if mwb_regwrite & mwb_rd!=0 & match; else latched data. Register 0 never fwd.
//  - alu_a = asel_shamt ? {0,shamt} : fwd_rs;  alu_b = bsel_imm ? imm : fwd_rt.
//    ex_store_data = fwd_rt always. alu_op = latched aluop (NOP after bubble/reset).
//  - load_use_o = ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt) & id_valid.
//    Hazard unit responds with bubble_i next edge; this block never self-stalls.
//  - Latency: ID fields visible at outputs 1 cycle after the load edge; forwarding 0 cycles.
//  - bubble_i and hold_i together: hold wins, bubble is dropped (requester must retain it).
// TESTING
//  - Reset mid-run: rstn low async -> ex_valid=0, alu_op=0000, alu_a/alu_b=0 without clock.
//  - ADD $3,$1,$2 with exm_rd=1 res=0x10, mwb_rd=1 res=0x20, mwb_rd2 res=5 -> alu_a=0x10, alu_b=5.
//  - $0 fwd: id_rs=0, exm_rd=0, exm_regwrite=1, exm_result=0xFFFF -> alu_a=latched data (0).
//  - SLL shamt=4, rt=7 -> alu_a=4, alu_b=7, alu_op passes unchanged; LUI imm=0x1234 -> alu_b=0x1234.
//  - LW $5 in EX, ID reads $5 -> load_use_o=1; bubble_i next edge -> ex_valid=0, ex_regwrite=0, op=NOP.
//  - hold 2 cycles while mwb_rd=6 (0xAB) retires; EX rs=6 -> alu_a stays 0xAB after source gone.

Source files
------------

// File: rtl/id_ex_operand_stage_if.sv
// ID/EX stage bus: decoded ID fields, EX/MEM and MEM/WB forwarding taps,
// and the EX-side operands and control bits that feed the ALU.
interface id_ex_operand_stage_if #(
    parameter int DW  = 32,
    parameter int RW  = 5,
    parameter int OPW = 4
);
    logic           hold_i;
    logic           bubble_i;
    logic           id_valid;
    logic [RW-1:0]  id_rs;
    logic [RW-1:0]  id_rt;
    logic [RW-1:0]  id_rd;
    logic [DW-1:0]  id_rs_data;
    logic [DW-1:0]  id_rt_data;
    logic [DW-1:0]  id_imm;
    logic [4:0]     id_shamt;
    logic [OPW-1:0] id_aluop;
    logic           id_bsel_imm;
    logic           id_asel_shamt;
    logic           id_regwrite;
    logic           id_memread;
    logic           id_memwrite;
    logic           id_memtoreg;
    logic           exm_regwrite;
    logic [RW-1:0]  exm_rd;
    logic [DW-1:0]  exm_result;
    logic           mwb_regwrite;
    logic [RW-1:0]  mwb_rd;
    logic [DW-1:0]  mwb_result;
    logic           ex_valid;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  ex_store_data;
    logic [RW-1:0]  ex_rd;
    logic           ex_regwrite;
    logic           ex_memread;
    logic           ex_memwrite;
    logic           ex_memtoreg;
    logic           load_use_o;

    modport master (
        output hold_i, bubble_i, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
               id_imm, id_shamt, id_aluop, id_bsel_imm, id_asel_shamt, id_regwrite,
               id_memread, id_memwrite, id_memtoreg, exm_regwrite, exm_rd, exm_result,
               mwb_regwrite, mwb_rd, mwb_result,
        input  ex_valid, alu_a, alu_b, alu_op, ex_store_data, ex_rd, ex_regwrite,
               ex_memread, ex_memwrite, ex_memtoreg, load_use_o
    );

    modport slave (
        input  hold_i, bubble_i, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
               id_imm, id_shamt, id_aluop, id_bsel_imm, id_asel_shamt, id_regwrite,
               id_memread, id_memwrite, id_memtoreg, exm_regwrite, exm_rd, exm_result,
               mwb_regwrite, mwb_rd, mwb_result,
        output ex_valid, alu_a, alu_b, alu_op, ex_store_data, ex_rd, ex_regwrite,
               ex_memread, ex_memwrite, ex_memtoreg, load_use_o
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use detection. Drives the ALU operands directly.
module id_ex_operand_stage #(
    parameter int DW  = 32,
    parameter int RW  = 5,
    parameter int OPW = 4
) (
    input logic                   clk,
    input logic                   rstn,
    id_ex_operand_stage_if.slave  bus
);
    logic           ex_valid_r;
    logic [RW-1:0]  rs_r, rt_r, rd_r;
    logic [DW-1:0]  rs_data_r, rt_data_r, imm_r;
    logic [4:0]     shamt_r;
    logic [OPW-1:0] aluop_r;
    logic           bsel_imm_r, asel_shamt_r;
    logic           regwrite_r, memread_r, memwrite_r, memtoreg_r;

    logic [DW-1:0]  fwd_rs_s, fwd_rt_s, cap_rs_s, cap_rt_s;

    // A producer forwards only when it writes a non-zero register matching the source.
    function automatic logic fwd_hit(input logic we, input logic [RW-1:0] dst,
                                     input logic [RW-1:0] src);
        fwd_hit = we & (dst != {RW{1'b0}}) & (dst == src);
    endfunction

    // Forwarded operands for the instruction currently held in EX (EX/MEM wins over MEM/WB).
    always_comb begin
        fwd_rs_s = rs_data_r;
        fwd_rt_s = rt_data_r;
        if (fwd_hit(bus.exm_regwrite, bus.exm_rd, rs_r)) begin
            fwd_rs_s = bus.exm_result;
        end else if (fwd_hit(bus.mwb_regwrite, bus.mwb_rd, rs_r)) begin
            fwd_rs_s = bus.mwb_result;
        end else begin
            fwd_rs_s = rs_data_r;
        end
        if (fwd_hit(bus.exm_regwrite, bus.exm_rd, rt_r)) begin
            fwd_rt_s = bus.exm_result;
        end else if (fwd_hit(bus.mwb_regwrite, bus.mwb_rd, rt_r)) begin
            fwd_rt_s = bus.mwb_result;
        end else begin
            fwd_rt_s = rt_data_r;
        end
    end

    // Capture-time bypass: a MEM/WB write landing this cycle is not yet in the regfile read.
    always_comb begin
        cap_rs_s = bus.id_rs_data;
        cap_rt_s = bus.id_rt_data;
        if (fwd_hit(bus.mwb_regwrite, bus.mwb_rd, bus.id_rs)) begin
            cap_rs_s = bus.mwb_result;
        end else begin
            cap_rs_s = bus.id_rs_data;
        end
        if (fwd_hit(bus.mwb_regwrite, bus.mwb_rd, bus.id_rt)) begin
            cap_rt_s = bus.mwb_result;
        end else begin
            cap_rt_s = bus.id_rt_data;
        end
    end

    // Stage register: hold refreshes operands, bubble inserts a NOP, otherwise load ID.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid_r   <= 1'b0;
            rs_r         <= {RW{1'b0}};
            rt_r         <= {RW{1'b0}};
            rd_r         <= {RW{1'b0}};
            rs_data_r    <= {DW{1'b0}};
            rt_data_r    <= {DW{1'b0}};
            imm_r        <= {DW{1'b0}};
            shamt_r      <= 5'd0;
            aluop_r      <= {OPW{1'b0}};
            bsel_imm_r   <= 1'b0;
            asel_shamt_r <= 1'b0;
            regwrite_r   <= 1'b0;
            memread_r    <= 1'b0;
            memwrite_r   <= 1'b0;
            memtoreg_r   <= 1'b0;
        end else if (bus.hold_i) begin
            // The forwarding source may retire while frozen, so latch its value now.
            rs_data_r <= fwd_rs_s;
            rt_data_r <= fwd_rt_s;
        end else if (bus.bubble_i) begin
            ex_valid_r <= 1'b0;
            rd_r       <= {RW{1'b0}};
            aluop_r    <= {OPW{1'b0}};
            regwrite_r <= 1'b0;
            memread_r  <= 1'b0;
            memwrite_r <= 1'b0;
            memtoreg_r <= 1'b0;
        end else begin
            ex_valid_r   <= bus.id_valid;
            rs_r         <= bus.id_rs;
            rt_r         <= bus.id_rt;
            rd_r         <= bus.id_rd;
            rs_data_r    <= cap_rs_s;
            rt_data_r    <= cap_rt_s;
            imm_r        <= bus.id_imm;
            shamt_r      <= bus.id_shamt;
            aluop_r      <= bus.id_aluop;
            bsel_imm_r   <= bus.id_bsel_imm;
            asel_shamt_r <= bus.id_asel_shamt;
            regwrite_r   <= bus.id_regwrite;
            memread_r    <= bus.id_memread;
            memwrite_r   <= bus.id_memwrite;
            memtoreg_r   <= bus.id_memtoreg;
        end
    end

    // ALU operand selection: shamt or forwarded rs for A, immediate or forwarded rt for B.
    always_comb begin
        if (asel_shamt_r) begin
            bus.alu_a = {{(DW-5){1'b0}}, shamt_r};
        end else begin
            bus.alu_a = fwd_rs_s;
        end
        if (bsel_imm_r) begin
            bus.alu_b = imm_r;
        end else begin
            bus.alu_b = fwd_rt_s;
        end
    end

    assign bus.ex_store_data = fwd_rt_s;
    assign bus.ex_valid      = ex_valid_r;
    assign bus.alu_op        = aluop_r;
    assign bus.ex_rd         = rd_r;
    assign bus.ex_regwrite   = regwrite_r;
    assign bus.ex_memread    = memread_r;
    assign bus.ex_memwrite   = memwrite_r;
    assign bus.ex_memtoreg   = memtoreg_r;

    // A load in EX whose destination is read by a valid ID instruction must be stalled.
    assign bus.load_use_o = ex_valid_r & memread_r & (rd_r != {RW{1'b0}}) &
                            ((rd_r == bus.id_rs) | (rd_r == bus.id_rt)) & bus.id_valid;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed tests for the ID/EX operand stage: reset, forwarding priority,
// register-0 handling, shift/immediate muxing, capture bypass, load-use, hold.
module tb_id_ex_operand_stage;
    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage_if #(.DW(32), .RW(5), .OPW(4)) bus ();

    id_ex_operand_stage #(.DW(32), .RW(5), .OPW(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic clear_inputs();
        bus.hold_i = 1'b0;        bus.bubble_i = 1'b0;      bus.id_valid = 1'b0;
        bus.id_rs = 5'd0;         bus.id_rt = 5'd0;         bus.id_rd = 5'd0;
        bus.id_rs_data = 32'd0;   bus.id_rt_data = 32'd0;   bus.id_imm = 32'd0;
        bus.id_shamt = 5'd0;      bus.id_aluop = 4'd0;      bus.id_bsel_imm = 1'b0;
        bus.id_asel_shamt = 1'b0; bus.id_regwrite = 1'b0;   bus.id_memread = 1'b0;
        bus.id_memwrite = 1'b0;   bus.id_memtoreg = 1'b0;
        bus.exm_regwrite = 1'b0;  bus.exm_rd = 5'd0;        bus.exm_result = 32'd0;
        bus.mwb_regwrite = 1'b0;  bus.mwb_rd = 5'd0;        bus.mwb_result = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 1'b0;
        step(); step();
        total += 5;
        if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.ex_valid); end
        if (bus.alu_op !== 4'b0000) begin bad++; $display("FAIL reset_op got=%b exp=0000", bus.alu_op); end
        if (bus.alu_a !== 32'd0) begin bad++; $display("FAIL reset_a got=%h exp=0", bus.alu_a); end
        if (bus.alu_b !== 32'd0) begin bad++; $display("FAIL reset_b got=%h exp=0", bus.alu_b); end
        if ({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0000",
                {bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg});
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_add_fwd();
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_rd = 5'd3;
        bus.id_rs_data = 32'h111; bus.id_rt_data = 32'h222; bus.id_aluop = 4'b0010;
        bus.id_regwrite = 1'b1;
        step();
        clear_inputs();
        bus.exm_regwrite = 1'b1; bus.exm_rd = 5'd1; bus.exm_result = 32'h10;
        bus.mwb_regwrite = 1'b1; bus.mwb_rd = 5'd1; bus.mwb_result = 32'h20;
        #1;
        total += 5;
        if (bus.alu_a !== 32'h10) begin bad++; $display("FAIL add_exm_priority got=%h exp=10", bus.alu_a); end
        if (bus.alu_b !== 32'h222) begin bad++; $display("FAIL add_b_latched got=%h exp=222", bus.alu_b); end
        if (bus.alu_op !== 4'b0010) begin bad++; $display("FAIL add_op got=%b exp=0010", bus.alu_op); end
        if (bus.ex_rd !== 5'd3) begin bad++; $display("FAIL add_rd got=%0d exp=3", bus.ex_rd); end
        if (bus.ex_valid !== 1'b1 || bus.ex_regwrite !== 1'b1) begin
            bad++; $display("FAIL add_ctrl got=%b%b exp=11", bus.ex_valid, bus.ex_regwrite);
        end
        bus.mwb_rd = 5'd2; bus.mwb_result = 32'h5;
        #1;
        total += 3;
        if (bus.alu_a !== 32'h10) begin bad++; $display("FAIL add_a_exm got=%h exp=10", bus.alu_a); end
        if (bus.alu_b !== 32'h5) begin bad++; $display("FAIL add_b_mwb got=%h exp=5", bus.alu_b); end
        if (bus.ex_store_data !== 32'h5) begin bad++; $display("FAIL add_store got=%h exp=5", bus.ex_store_data); end
        bus.exm_regwrite = 1'b0; bus.mwb_rd = 5'd1; bus.mwb_result = 32'h20;
        #1;
        total += 2;
        if (bus.alu_a !== 32'h20) begin bad++; $display("FAIL add_a_mwb got=%h exp=20", bus.alu_a); end
        if (bus.alu_b !== 32'h222) begin bad++; $display("FAIL add_b_nofwd got=%h exp=222", bus.alu_b); end
        clear_inputs();
        step();
    endtask

    task automatic test_zero_reg();
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_aluop = 4'b0010;
        bus.exm_regwrite = 1'b1; bus.exm_rd = 5'd0; bus.exm_result = 32'hFFFF;
        bus.mwb_regwrite = 1'b1; bus.mwb_rd = 5'd0; bus.mwb_result = 32'hFFFF;
        step();
        total += 2;
        if (bus.alu_a !== 32'd0) begin bad++; $display("FAIL zero_a got=%h exp=0", bus.alu_a); end
        if (bus.alu_b !== 32'd0) begin bad++; $display("FAIL zero_b got=%h exp=0", bus.alu_b); end
        clear_inputs();
        step();
    endtask

    task automatic test_shift_imm();
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rt = 5'd7; bus.id_rt_data = 32'd7; bus.id_rd = 5'd8;
        bus.id_shamt = 5'd4; bus.id_asel_shamt = 1'b1; bus.id_aluop = 4'b1000;
        bus.id_rs_data = 32'hDEAD;
        step();
        total += 3;
        if (bus.alu_a !== 32'd4) begin bad++; $display("FAIL sll_a got=%h exp=4", bus.alu_a); end
        if (bus.alu_b !== 32'd7) begin bad++; $display("FAIL sll_b got=%h exp=7", bus.alu_b); end
        if (bus.alu_op !== 4'b1000) begin bad++; $display("FAIL sll_op got=%b exp=1000", bus.alu_op); end
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rt = 5'd9; bus.id_rt_data = 32'h77; bus.id_rd = 5'd9;
        bus.id_imm = 32'h1234; bus.id_bsel_imm = 1'b1; bus.id_aluop = 4'b1011;
        step();
        total += 2;
        if (bus.alu_b !== 32'h1234) begin bad++; $display("FAIL lui_b got=%h exp=1234", bus.alu_b); end
        if (bus.ex_store_data !== 32'h77) begin bad++; $display("FAIL lui_store got=%h exp=77", bus.ex_store_data); end
        clear_inputs();
        step();
    endtask

    task automatic test_capture_bypass();
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rs = 5'd4; bus.id_rt = 5'd4;
        bus.id_rs_data = 32'h1; bus.id_rt_data = 32'h2;
        bus.mwb_regwrite = 1'b1; bus.mwb_rd = 5'd4; bus.mwb_result = 32'h99;
        step();
        clear_inputs();
        #1;
        total += 2;
        if (bus.alu_a !== 32'h99) begin bad++; $display("FAIL bypass_a got=%h exp=99", bus.alu_a); end
        if (bus.alu_b !== 32'h99) begin bad++; $display("FAIL bypass_b got=%h exp=99", bus.alu_b); end
        step();
    endtask

    task automatic test_load_use();
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rs = 5'd1; bus.id_rt = 5'd5; bus.id_rd = 5'd5;
        bus.id_memread = 1'b1; bus.id_regwrite = 1'b1; bus.id_memtoreg = 1'b1;
        bus.id_aluop = 4'b0010; bus.id_bsel_imm = 1'b1; bus.id_imm = 32'd4;
        step();
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rs = 5'd5; bus.id_rt = 5'd3;
        #1;
        total += 1;
        if (bus.load_use_o !== 1'b1) begin bad++; $display("FAIL lu_rs got=%b exp=1", bus.load_use_o); end
        bus.id_rs = 5'd3; bus.id_rt = 5'd5;
        #1;
        total += 1;
        if (bus.load_use_o !== 1'b1) begin bad++; $display("FAIL lu_rt got=%b exp=1", bus.load_use_o); end
        bus.id_valid = 1'b0;
        #1;
        total += 1;
        if (bus.load_use_o !== 1'b0) begin bad++; $display("FAIL lu_idinvalid got=%b exp=0", bus.load_use_o); end
        bus.id_valid = 1'b1; bus.id_rs = 5'd2; bus.id_rt = 5'd3;
        #1;
        total += 1;
        if (bus.load_use_o !== 1'b0) begin bad++; $display("FAIL lu_nomatch got=%b exp=0", bus.load_use_o); end
        bus.id_rs = 5'd5; bus.bubble_i = 1'b1;
        step();
        total += 4;
        if (bus.ex_valid !== 1'b0 || bus.ex_regwrite !== 1'b0) begin
            bad++; $display("FAIL bubble_ctrl got=%b%b exp=00", bus.ex_valid, bus.ex_regwrite);
        end
        if (bus.alu_op !== 4'b0000) begin bad++; $display("FAIL bubble_op got=%b exp=0000", bus.alu_op); end
        if (bus.ex_memread !== 1'b0 || bus.ex_rd !== 5'd0) begin
            bad++; $display("FAIL bubble_mem got=%b/%0d exp=0/0", bus.ex_memread, bus.ex_rd);
        end
        if (bus.load_use_o !== 1'b0) begin bad++; $display("FAIL bubble_lu got=%b exp=0", bus.load_use_o); end
        clear_inputs();
        step();
    endtask

    task automatic test_hold();
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rs = 5'd6; bus.id_rs_data = 32'h1; bus.id_rd = 5'd10;
        bus.id_aluop = 4'b0010; bus.id_regwrite = 1'b1;
        step();
        clear_inputs();
        bus.mwb_regwrite = 1'b1; bus.mwb_rd = 5'd6; bus.mwb_result = 32'hAB; bus.hold_i = 1'b1;
        #1;
        total += 1;
        if (bus.alu_a !== 32'hAB) begin bad++; $display("FAIL hold_fwd got=%h exp=ab", bus.alu_a); end
        step();
        bus.mwb_regwrite = 1'b0; bus.mwb_result = 32'h0;
        bus.bubble_i = 1'b1; bus.id_valid = 1'b1; bus.id_aluop = 4'b0110; bus.id_rd = 5'd12;
        #1;
        total += 1;
        if (bus.alu_a !== 32'hAB) begin bad++; $display("FAIL hold_retired got=%h exp=ab", bus.alu_a); end
        step();
        total += 3;
        if (bus.alu_a !== 32'hAB) begin bad++; $display("FAIL hold_2cyc got=%h exp=ab", bus.alu_a); end
        if (bus.ex_valid !== 1'b1 || bus.alu_op !== 4'b0010) begin
            bad++; $display("FAIL hold_over_bubble got=%b/%b exp=1/0010", bus.ex_valid, bus.alu_op);
        end
        if (bus.ex_rd !== 5'd10) begin bad++; $display("FAIL hold_rd got=%0d exp=10", bus.ex_rd); end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_midrun();
        clear_inputs();
        bus.id_valid = 1'b1; bus.id_rs = 5'd11; bus.id_rt = 5'd12;
        bus.id_rs_data = 32'h55; bus.id_rt_data = 32'h66; bus.id_aluop = 4'b0111;
        step();
        total += 1;
        if (bus.alu_a !== 32'h55) begin bad++; $display("FAIL pre_reset_a got=%h exp=55", bus.alu_a); end
        #2;
        rstn = 1'b0;
        #1;
        total += 4;
        if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b exp=0", bus.ex_valid); end
        if (bus.alu_op !== 4'b0000) begin bad++; $display("FAIL async_op got=%b exp=0000", bus.alu_op); end
        if (bus.alu_a !== 32'd0) begin bad++; $display("FAIL async_a got=%h exp=0", bus.alu_a); end
        if (bus.alu_b !== 32'd0) begin bad++; $display("FAIL async_b got=%h exp=0", bus.alu_b); end
        @(negedge clk);
        rstn = 1'b1;
        clear_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_add_fwd();
        test_zero_reg();
        test_shift_imm();
        test_capture_bypass();
        test_load_use();
        test_hold();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
